ex_mem_stage: RTL and testbench

//  EX->MEM pipeline register directly downstream of the ALU. Captures the ALU result/status

---
 rtl/ex_mem_pkg.sv | 18 +
 rtl/ex_exc_detect.sv | 23 ++
 rtl/ex_mem_stage.sv | 91 +++++++++
 tb/tb_ex_mem_stage.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared state, cause, status-bit and control-bit definitions for the EX->MEM stage
package ex_mem_pkg;
    typedef enum logic [1:0] {S_EMPTY, S_FULL, S_EXC_HOLD} state_t;
    localparam logic [4:0] CAUSE_ADEL = 5'd4;
    localparam logic [4:0] CAUSE_ADES = 5'd5;
    localparam logic [4:0] CAUSE_OV   = 5'd12;
    localparam logic [4:0] CAUSE_DIV0 = 5'd15;
    localparam int STAT_ZERO     = 7;
    localparam int STAT_MUL_OVF  = 6;
    localparam int STAT_ADD_OVF  = 5;
    localparam int STAT_NEG      = 4;
    localparam int STAT_MISALIGN = 3;
    localparam int STAT_DIV0     = 2;
    localparam int CTL_REG_WRITE  = 3;
    localparam int CTL_MEM_TO_REG = 2;
    localparam int CTL_MEM_READ   = 1;
    localparam int CTL_MEM_WRITE  = 0;
endpackage

// File: rtl/ex_exc_detect.sv
// ex_exc_detect: masks ALU status flags and picks the highest-priority exception cause
module ex_exc_detect
    import ex_mem_pkg::*;
#(
    parameter logic [7:0] EXC_MASK = 8'b0110_1100
) (
    input  logic [7:0] status,
    input  logic       trap_en,
    input  logic       mem_read,
    input  logic       mem_write,
    output logic       hit,
    output logic [4:0] cause
);
    logic [7:0] qual;
    logic [7:0] g;
    // misalign only matters for memory ops, overflow only for trapping arithmetic
    assign qual = {1'b0, trap_en, trap_en, 1'b0, mem_read | mem_write, 1'b1, 2'b00};
    assign g = status & EXC_MASK & qual;
    assign hit = |g;
    assign cause = g[STAT_MISALIGN] ? (mem_read ? CAUSE_ADEL : CAUSE_ADES) :
                   (g[STAT_MUL_OVF] | g[STAT_ADD_OVF]) ? CAUSE_OV :
                   g[STAT_DIV0] ? CAUSE_DIV0 : 5'd0;
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with valid/ready flow control and precise ALU exceptions
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter logic [7:0]  EXC_MASK = 8'b0110_1100,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic [7:0]  alu_status,
    input  logic        trap_en,
    input  logic [31:0] pc_in,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_reg,
    input  logic [3:0]  ctl_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result_out,
    output logic [31:0] store_out,
    output logic [4:0]  dest_out,
    output logic [3:0]  ctl_out,
    output logic        zero_out,
    output logic        exc_valid,
    output logic [4:0]  exc_cause,
    output logic [31:0] epc_out,
    output logic        exc_pending,
    input  logic        exc_clear
);
    state_t     state, state_nx;
    logic       accept;
    logic       hit;
    logic [4:0] cause;

    ex_exc_detect #(.EXC_MASK(EXC_MASK)) u_det (
        .status   (alu_status),
        .trap_en  (trap_en),
        .mem_read (ctl_in[CTL_MEM_READ]),
        .mem_write(ctl_in[CTL_MEM_WRITE]),
        .hit      (hit),
        .cause    (cause)
    );

    assign in_ready    = (state != S_EXC_HOLD) && (state == S_EMPTY || out_ready);
    assign accept      = in_valid && in_ready && !flush;
    assign out_valid   = state == S_FULL;
    assign exc_pending = state == S_EXC_HOLD;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_EMPTY;
        else        state <= state_nx;
    end

    // only exc_clear leaves the hold state; flush beats any accept
    always_comb begin
        state_nx = state;
        state_nx = (state == S_EXC_HOLD) ? (exc_clear ? S_EMPTY : S_EXC_HOLD) :
                   flush  ? S_EMPTY :
                   accept ? (hit ? S_EXC_HOLD : S_FULL) :
                   (state == S_FULL && out_ready) ? S_EMPTY : state;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_out <= '0;
            store_out  <= '0;
            dest_out   <= '0;
            ctl_out    <= '0;
            zero_out   <= 1'b0;
            exc_valid  <= 1'b0;
            exc_cause  <= '0;
            epc_out    <= RESET_PC;
        end else begin
            exc_valid <= accept && hit;
            if (accept) begin
                result_out <= alu_result;
                store_out  <= store_data;
                dest_out   <= dest_reg;
                ctl_out    <= hit ? 4'd0 : ctl_in;
                zero_out   <= alu_status[STAT_ZERO];
                if (hit) begin
                    epc_out   <= pc_in;
                    exc_cause <= cause;
                end
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed stimulus, per-cycle compare against a behavioural model plus literal checks
module tb_ex_mem_stage;
    logic        clk = 0;
    logic        rst_n, in_valid, in_ready, trap_en, flush, out_valid, out_ready;
    logic [31:0] alu_result, pc_in, store_data, result_out, store_out, epc_out;
    logic [7:0]  alu_status;
    logic [4:0]  dest_reg, dest_out, exc_cause;
    logic [3:0]  ctl_in, ctl_out;
    logic        zero_out, exc_valid, exc_pending, exc_clear;

    int errors = 0;
    int checks = 0;
    bit armed = 0;

    ex_mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_status(alu_status), .trap_en(trap_en),
        .pc_in(pc_in), .store_data(store_data), .dest_reg(dest_reg), .ctl_in(ctl_in),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result_out(result_out), .store_out(store_out), .dest_out(dest_out),
        .ctl_out(ctl_out), .zero_out(zero_out), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .epc_out(epc_out), .exc_pending(exc_pending),
        .exc_clear(exc_clear)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: one slot that is empty, holds a word, or is frozen on an exception
    bit          m_full = 0, m_hold = 0, m_excv = 0, m_zero = 0, take;
    logic [31:0] m_res = 0, m_st = 0, m_epc = 0;
    logic [4:0]  m_dest = 0, m_cause = 0;
    logic [3:0]  m_ctl = 0;
    int          code;

    function automatic bit m_rdy();
        return !m_hold && (!m_full || out_ready);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_full = 0; m_hold = 0; m_excv = 0; m_epc = 0; m_cause = 0;
        end else begin
            take = in_valid && m_rdy() && !flush;
            code = -1;
            if (alu_status[3] && (ctl_in[1] || ctl_in[0])) code = ctl_in[1] ? 4 : 5;
            else if (trap_en && (alu_status[5] || alu_status[6])) code = 12;
            else if (alu_status[2]) code = 15;
            m_excv = take && code >= 0;
            if (m_hold) begin
                if (exc_clear) m_hold = 0;
            end else if (flush) begin
                m_full = 0;
            end else if (take) begin
                m_res = alu_result; m_st = store_data; m_dest = dest_reg; m_zero = alu_status[7];
                if (code >= 0) begin
                    m_hold = 1; m_full = 0; m_ctl = 0; m_epc = pc_in; m_cause = 5'(code);
                end else begin
                    m_full = 1; m_ctl = ctl_in;
                end
            end else if (m_full && out_ready) begin
                m_full = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy()});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
            chk("exc_valid", {31'd0, exc_valid}, {31'd0, m_excv});
            chk("exc_pending", {31'd0, exc_pending}, {31'd0, m_hold});
            chk("epc_out", epc_out, m_epc);
            chk("exc_cause", {27'd0, exc_cause}, {27'd0, m_cause});
            if (m_full) begin
                chk("result_out", result_out, m_res);
                chk("store_out", store_out, m_st);
                chk("dest_out", {27'd0, dest_out}, {27'd0, m_dest});
                chk("ctl_out", {28'd0, ctl_out}, {28'd0, m_ctl});
                chk("zero_out", {31'd0, zero_out}, {31'd0, m_zero});
            end
            if (m_hold) chk("ctl_out_hold", {28'd0, ctl_out}, 32'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [31:0] res, logic [7:0] st, logic te, logic [31:0] pc,
                         logic [31:0] sd, logic [4:0] rd, logic [3:0] c);
        in_valid = 1; alu_result = res; alu_status = st; trap_en = te;
        pc_in = pc; store_data = sd; dest_reg = rd; ctl_in = c;
    endtask

    task automatic clear_exc();
        exc_clear = 1;
        step();
        exc_clear = 0;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 1; flush = 0; exc_clear = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        in_valid = 0;
        step(); step();
        armed = 1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_pending", {31'd0, exc_pending}, 32'd0);
        chk("rst_epc", epc_out, 32'h0);
        chk("rst_ctl", {28'd0, ctl_out}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1;
        // add 5+7
        drive(12, 8'h00, 1, 32'h100, 32'h0, 3, 4'b1000);
        step(); in_valid = 0;
        chk("t1_result", result_out, 32'd12);
        chk("t1_valid", {31'd0, out_valid}, 32'd1);
        chk("t1_ctl", {28'd0, ctl_out}, 32'h8);
        step();
        chk("t1_drained", {31'd0, out_valid}, 32'd0);
        // backpressure
        drive(32'hAA, 8'h00, 0, 32'h104, 32'h55, 4, 4'b0001); out_ready = 0;
        step();
        drive(32'hBB, 8'h80, 0, 32'h108, 32'h66, 5, 4'b1000);
        step();
        chk("t2_hold1", result_out, 32'hAA);
        chk("t2_ready0", {31'd0, in_ready}, 32'd0);
        step();
        chk("t2_hold2", result_out, 32'hAA);
        chk("t2_store", store_out, 32'h55);
        out_ready = 1; #1;
        chk("t2_ready1", {31'd0, in_ready}, 32'd1);
        step(); in_valid = 0;
        chk("t2_next", result_out, 32'hBB);
        chk("t2_zero", {31'd0, zero_out}, 32'd1);
        step();
        // load misalign
        drive(0, 8'h08, 0, 32'h200, 0, 7, 4'b1110);
        step(); in_valid = 0;
        chk("t3_excv", {31'd0, exc_valid}, 32'd1);
        chk("t3_cause", {27'd0, exc_cause}, 32'd4);
        chk("t3_epc", epc_out, 32'h200);
        chk("t3_ctl", {28'd0, ctl_out}, 32'd0);
        chk("t3_outv", {31'd0, out_valid}, 32'd0);
        step();
        chk("t3_pulse", {31'd0, exc_valid}, 32'd0);
        flush = 1; step(); flush = 0;
        chk("t3_flush_ignored", {31'd0, exc_pending}, 32'd1);
        clear_exc();
        chk("t3_cleared", {31'd0, exc_pending}, 32'd0);
        chk("t3_epc_kept", epc_out, 32'h200);
        // trapping add with overflow and div0
        drive(0, 8'h24, 1, 32'h300, 0, 8, 4'b1000);
        step(); in_valid = 0;
        chk("t4_cause", {27'd0, exc_cause}, 32'd12);
        clear_exc();
        chk("t4_ready", {31'd0, in_ready}, 32'd1);
        // addu overflow is silent, then div0
        drive(9, 8'h20, 0, 32'h304, 0, 9, 4'b1000);
        step();
        chk("t5_result", result_out, 32'd9);
        chk("t5_noexc", {31'd0, exc_valid}, 32'd0);
        drive(0, 8'h04, 0, 32'h308, 0, 10, 4'b1000);
        step(); in_valid = 0;
        chk("t5_cause", {27'd0, exc_cause}, 32'd15);
        chk("t5_epc", epc_out, 32'h308);
        clear_exc();
        // store misalign, then misalign on a non-memory op
        drive(0, 8'h08, 0, 32'h30C, 0, 0, 4'b0001);
        step(); in_valid = 0;
        chk("t5_ades", {27'd0, exc_cause}, 32'd5);
        clear_exc();
        drive(32'h1234, 8'h08, 0, 32'h310, 0, 11, 4'b1000);
        step(); in_valid = 0;
        chk("t5_alu_mis", {31'd0, out_valid}, 32'd1);
        step();
        // flush beats a same-cycle exception
        out_ready = 0;
        drive(1, 8'h00, 0, 32'h400, 0, 1, 4'b1000);
        step();
        drive(0, 8'h08, 0, 32'h500, 0, 2, 4'b0010); flush = 1;
        step(); flush = 0; in_valid = 0;
        chk("t6_empty", {31'd0, out_valid}, 32'd0);
        chk("t6_noexc", {31'd0, exc_valid}, 32'd0);
        chk("t6_epc", epc_out, 32'h30C);
        out_ready = 1;
        // reset while frozen
        drive(0, 8'h04, 0, 32'h600, 0, 0, 4'b0000);
        step(); in_valid = 0;
        chk("t6_hold", {31'd0, exc_pending}, 32'd1);
        rst_n = 0; step();
        chk("t6_rst_pending", {31'd0, exc_pending}, 32'd0);
        chk("t6_rst_epc", epc_out, 32'h0);
        chk("t6_rst_cause", {27'd0, exc_cause}, 32'd0);
        chk("t6_rst_excv", {31'd0, exc_valid}, 32'd0);
        rst_n = 1;
        step(); step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
